uart_rx_crc: RTL and testbench
==============================

# uart_rx_crc

Parametrised UART receiver with an appended serial CRC check. It is the next-generation receive path behind `uart_top`, generalised in data width, CRC width/polynomial and baud divisor. It deserialises one frame: a start bit, then `DATA_WIDTH` data bits LSB-first, then `CRC_WIDTH` CRC bits MSB-first, then one stop bit. It reports the data word together with CRC-error and framing-error status, and rejects start-bit glitches.

## Interface
- `CLKS_PER_BIT`, 1042: clock cycles per bit (10 MHz / 9600 baud); minimum 4.
- `DATA_WIDTH`, 8: payload bits per frame; minimum 1.
- `CRC_WIDTH`, 4: CRC bits per frame; minimum 1.
- `CRC_POLY`, 4'b0011: generator polynomial without the implicit top term (x^4+x+1); width `CRC_WIDTH`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `rx` in 1: asynchronous serial input; idles high.
- `data_out` out DATA_WIDTH: last received payload; held until the next completion.
- `data_valid` out 1: one-cycle pulse on frame completion.
- `crc_error` out 1: CRC status of the last frame; 1 = mismatch. Updated with `data_valid`.
- `frame_error` out 1: stop-bit status of the last frame; 1 = stop bit sampled 0. Updated with `data_valid`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- **Input sync**: `rx` passes through a two-flop synchroniser (`rx_s`). Both flops reset to 1. All logic uses `rx_s` only.
- **Constants**: HALF = CLKS_PER_BIT/2, integer floor.
- **Counters**:
  - Baud counter `cnt`: width ceil(log2(CLKS_PER_BIT)).
  - Bit index `idx`: width covering max(DATA_WIDTH, CRC_WIDTH).
- **CRC register** `crc`, CRC_WIDTH bits, cleared at every start. Per sampled bit b:
  - fb = crc[MSB] ^ b
  - crc = (crc << 1) ^ (fb ? CRC_POLY : 0)
  - Applied to the data bits and to the received CRC bits alike.
  - A good frame leaves residue 0, so crc_error = (crc ≠ 0) after the last CRC bit.
- **States**:
  - IDLE: cnt=0. On rx_s==0, go to START with cnt=0.
  - START: cnt increments. At cnt==HALF-1, sample rx_s.
    - If 1: glitch; return to IDLE, no flags change.
    - If 0: go to DATA with cnt=0, idx=0, crc=0.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s.
    - Shift the bit into data shift register position idx (LSB first) and update crc.
    - cnt=0, idx++.
    - After bit DATA_WIDTH-1, go to CRC_RX with idx=0.
  - CRC_RX: same sampling cadence; each bit updates crc only. After bit CRC_WIDTH-1, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample the stop bit.
    - Register data_out, crc_error = |crc, frame_error = ~rx_s.
    - Pulse data_valid.
    - If the stop bit was 1, go to IDLE; else go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. A held-low line (break) never retriggers a frame.
- **Reset**: applies in any state, including mid-frame. The partial frame is discarded; no data_valid is produced for it.
- **Error precedence**: crc_error and frame_error are independent; both may be 1 on the same pulse. data_out is updated even on error.

## Timing
- **Reset values**:
  - data_out=0, data_valid=0, crc_error=0, frame_error=0, busy=0.
  - state=IDLE; sync flops=1.
- **Sample points**: with t0 = the first cycle rx_s==0 in IDLE, data bit k is sampled at t0 + HALF + (k+1)·CLKS_PER_BIT. This places every sample at mid-bit ±1 cycle.
- **Latency**: data_valid is high in cycle t0 + HALF + (DATA_WIDTH+CRC_WIDTH+1)·CLKS_PER_BIT + 1. Relative to the raw `rx` edge, add 2 cycles for the synchroniser.
- **Back-to-back frames**: the next start bit may follow the stop bit immediately. IDLE is re-entered by mid-stop, which leaves half a bit of margin.
- **Glitch rejection**: any low pulse shorter than HALF cycles is ignored.
- **Output hold**: data_valid is exactly 1 cycle wide. The other outputs hold until the next data_valid or reset.

## Test plan
Bench parameters: CLKS_PER_BIT=16; other parameters at default.
- **Good frame**: send 0x01 with CRC 4'b1110, stop bit 1 -> single data_valid at the computed cycle; data_out=0x01, crc_error=0, frame_error=0, busy low 1 cycle after.
- **CRC error**: send 0x01 with CRC 4'b1111 -> data_out=0x01, crc_error=1, frame_error=0.
- **Break / framing error**: send 0x00 with CRC 4'b0000, then hold rx=0 for 5 bit times -> one data_valid with frame_error=1, crc_error=0; no second frame; busy stays high until rx returns high.
- **Start glitch**: rx low for 6 cycles, then high -> no data_valid, busy returns to 0, flags unchanged from the prior frame.
- **Reset mid-frame**: assert rst for 1 cycle during data bit 3 -> all outputs 0 the next cycle. A following clean 0x00/4'b0000 frame is received with no errors.
- **Back-to-back**: send 0x01/4'b1110 immediately followed by 0x00/4'b0000 -> two data_valid pulses exactly 14·16 cycles apart, both error-free.

Source files
------------

// File: rtl/uart_rx_crc.sv
// UART receiver: start bit, DATA_WIDTH data bits LSB-first, CRC_WIDTH CRC bits MSB-first, one stop bit.
// Reports the payload with CRC-residue and stop-bit status; rejects start-bit glitches.
module uart_rx_crc #(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CRC_WIDTH    = 4,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY = CRC_WIDTH'(4'b0011)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  crc_error,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int unsigned HALF    = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_MAX = (DATA_WIDTH > CRC_WIDTH) ? DATA_WIDTH : CRC_WIDTH;
  localparam int unsigned IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC_RX,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                r_state;
  logic                  r_rx_meta;
  logic                  r_rx_s;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [CRC_WIDTH-1:0]  r_crc;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_crc_error;
  logic                  r_frame_error;
  logic                  r_busy;

  logic                  w_bit_end;
  logic                  w_half_end;
  logic                  w_fb;
  logic [CRC_WIDTH-1:0]  w_crc_next;

  // Serial CRC step for the currently sampled bit; the same step covers data and CRC bits.
  assign w_fb       = r_crc[CRC_WIDTH-1] ^ r_rx_s;
  assign w_crc_next = (r_crc << 1) ^ (w_fb ? CRC_POLY : CRC_WIDTH'(0));
  assign w_bit_end  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_half_end = (r_cnt == CNT_W'(HALF - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_crc         <= '0;
      r_shift       <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_crc_error   <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rx_meta    <= rx;
      r_rx_s       <= r_rx_meta;
      r_data_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end

        // Mid-start check: a line that is high again was only a glitch.
        S_START: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= '0;
              r_crc   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= r_rx_s;
            r_crc          <= w_crc_next;
            if (r_idx == IDX_W'(DATA_WIDTH - 1)) begin
              r_idx   <= '0;
              r_state <= S_CRC_RX;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_CRC_RX: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            r_crc <= w_crc_next;
            if (r_idx == IDX_W'(CRC_WIDTH - 1)) begin
              r_idx   <= '0;
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // Report at mid-stop; a low stop bit parks in WAIT_HIGH so a break never retriggers.
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt         <= '0;
            r_data_out    <= r_shift;
            r_crc_error   <= |r_crc;
            r_frame_error <= ~r_rx_s;
            r_data_valid  <= 1'b1;
            if (r_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_HIGH: begin
          r_cnt <= '0;
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign crc_error   = r_crc_error;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_crc.sv
// Directed bench for uart_rx_crc at 16 clocks per bit with hand-computed CRC frames.
module tb_uart_rx_crc;

  localparam int unsigned CPB  = 16;
  localparam int unsigned HALF = CPB / 2;
  // Raw rx fall to data_valid: 2 sync flops + IDLE decision + HALF + 13 bit times.
  localparam int unsigned LAT  = 3 + HALF + 13 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       crc_error;
  logic       frame_error;
  logic       busy;

  int unsigned cyc            = 0;
  int unsigned n_valid        = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned n_checks       = 0;
  int unsigned n_errors       = 0;
  int unsigned t_start        = 0;
  int unsigned nv;
  int unsigned t1;
  int unsigned s1;

  uart_rx_crc #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH  (8),
    .CRC_WIDTH   (4),
    .CRC_POLY    (4'b0011)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .crc_error  (crc_error),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count data_valid pulses and remember the cycle of the latest one.
  always @(negedge clk) begin
    if (data_valid) begin
      n_valid        = n_valid + 1;
      last_valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [3:0] c, input logic stop);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    for (int i = 3; i >= 0; i--) drive_bit(c[i]);
    drive_bit(stop);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(data_out),    32'h0);
    check("rst_valid", 32'(data_valid),  32'h0);
    check("rst_crc",   32'(crc_error),   32'h0);
    check("rst_frame", 32'(frame_error), 32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Good frame: 0x01 leaves residue 1110, so sending 1110 gives zero.
    nv = n_valid;
    send_frame(8'h01, 4'b1110, 1'b1);
    check("good_count", n_valid, nv + 1);
    check("good_lat",   last_valid_cyc, t_start + LAT);
    check("good_data",  32'(data_out),    32'h01);
    check("good_crc",   32'(crc_error),   32'h0);
    check("good_frame", 32'(frame_error), 32'h0);
    check("good_busy",  32'(busy),        32'h0);

    // Wrong CRC: final bit 1 leaves residue 0011.
    nv = n_valid;
    send_frame(8'h01, 4'b1111, 1'b1);
    check("crcerr_count", n_valid, nv + 1);
    check("crcerr_lat",   last_valid_cyc, t_start + LAT);
    check("crcerr_data",  32'(data_out),    32'h01);
    check("crcerr_crc",   32'(crc_error),   32'h1);
    check("crcerr_frame", 32'(frame_error), 32'h0);

    // Start glitch of 6 cycles (< HALF).
    nv = n_valid;
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_hi", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("glitch_count", n_valid, nv);
    check("glitch_busy",  32'(busy),        32'h0);
    check("glitch_data",  32'(data_out),    32'h01);
    check("glitch_crc",   32'(crc_error),   32'h1);
    check("glitch_frame", 32'(frame_error), 32'h0);

    // Break: stop bit low and line held low for 5 bit times total.
    nv = n_valid;
    send_frame(8'h00, 4'b0000, 1'b0);
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("brk_count", n_valid, nv + 1);
    check("brk_lat",   last_valid_cyc, t_start + LAT);
    check("brk_data",  32'(data_out),    32'h00);
    check("brk_crc",   32'(crc_error),   32'h0);
    check("brk_frame", 32'(frame_error), 32'h1);
    check("brk_busy",  32'(busy),        32'h1);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("brk_busy_rel", 32'(busy), 32'h0);
    repeat (2 * CPB) @(posedge clk);
    #1;
    check("brk_no_second", n_valid, nv + 1);

    // Reset in the middle of data bit 3 of an all-ones frame.
    nv = n_valid;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_data",  32'(data_out),    32'h0);
    check("mid_rst_valid", 32'(data_valid),  32'h0);
    check("mid_rst_crc",   32'(crc_error),   32'h0);
    check("mid_rst_frame", 32'(frame_error), 32'h0);
    check("mid_rst_busy",  32'(busy),        32'h0);
    repeat (3 * CPB) @(posedge clk);
    #1;
    check("mid_rst_nopulse", n_valid, nv);
    send_frame(8'h00, 4'b0000, 1'b1);
    check("post_rst_count", n_valid, nv + 1);
    check("post_rst_lat",   last_valid_cyc, t_start + LAT);
    check("post_rst_data",  32'(data_out),    32'h00);
    check("post_rst_crc",   32'(crc_error),   32'h0);
    check("post_rst_frame", 32'(frame_error), 32'h0);

    // Back-to-back: second start bit right after the first stop bit.
    nv = n_valid;
    send_frame(8'h01, 4'b1110, 1'b1);
    s1 = t_start;
    t1 = last_valid_cyc;
    check("b2b_lat1",  t1, s1 + LAT);
    check("b2b_data1", 32'(data_out),  32'h01);
    check("b2b_crc1",  32'(crc_error), 32'h0);
    send_frame(8'h00, 4'b0000, 1'b1);
    check("b2b_count", n_valid, nv + 2);
    check("b2b_gap",   last_valid_cyc - t1, 14 * CPB);
    check("b2b_data2", 32'(data_out),    32'h00);
    check("b2b_crc2",  32'(crc_error),   32'h0);
    check("b2b_frame", 32'(frame_error), 32'h0);
    check("b2b_busy",  32'(busy),        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
